// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, captures {pc, word} into a prefetch FIFO for decode.
// Latency: a word fetched at edge N heads the FIFO after edge N; a redirect flushes and its target is valid one edge later.
// Backpressure: instr_ready low holds the head; a full FIFO stops fetch and holds PC. FETCH_MISALIGN_CHECK_EN adds misaligned-redirect halt.
module fetch_unit #(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] RESET_PC    = 32'hBFC00000,
  parameter int                     FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [INSTR_WIDTH-1:0] PC,
  input  logic [DATA_WIDTH-1:0]  imem_instr,
  input  logic                   redirect_valid,
  input  logic [INSTR_WIDTH-1:0] redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_WIDTH-1:0]  instr,
  output logic [INSTR_WIDTH-1:0] instr_pc,
  output logic                   misalign
);

  localparam int                     PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]         FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [INSTR_WIDTH-1:0] PC_STEP  = INSTR_WIDTH'(4);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]  word;
  } entry_t;

  entry_t                 fifo_mem [FIFO_DEPTH];
  entry_t                 head;
  logic [INSTR_WIDTH-1:0] fpc;
  logic [INSTR_WIDTH-1:0] target_pc;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W:0]         count;
  logic                   run;
  logic                   push;
  logic                   pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {RUN, HALT} mode_t;

  mode_t mode;
  mode_t mode_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= RUN;
    end else begin
      mode <= mode_nxt;
    end
  end

  // Only a redirect can leave HALT; its alignment decides the new mode.
  always_comb begin
    mode_nxt = mode;
    if (redirect_valid) begin
      mode_nxt = (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
    end
  end

  assign run       = (mode == RUN);
  assign misalign  = (mode == HALT);
  assign target_pc = redirect_pc;
`else
  assign run       = 1'b1;
  assign misalign  = 1'b0;
  assign target_pc = redirect_pc & ~INSTR_WIDTH'(3);
`endif

  assign instr_valid = (count != '0);
  assign push        = run && (count < FULL_CNT) && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  assign head     = fifo_mem[rd_ptr];
  assign instr    = head.word;
  assign instr_pc = head.pc;
  assign PC       = fpc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      fpc    <= target_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        fpc    <= fpc + PC_STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr] <= {fpc, imem_instr};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'hBFC00000;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign       (misalign)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return ~a ^ 32'h5A5A0F0F;
  endfunction

  assign imem_instr = rom(PC);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %h, expected %h", name, n_vec, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic check_out(input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                           input logic e_mis);
    chk("PC", PC, e_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_vld));
    chk("misalign", 32'(misalign), 32'(e_mis));
    if (e_vld) begin
      chk("instr_pc", instr_pc, e_ipc);
      chk("instr", instr, rom(e_ipc));
    end
  endtask

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_ipc);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_vld = e_vld; v.e_pc = e_pc; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Reset, then streaming with instr_ready held high.
    add(1, 0, 0, 0, 0, RPC,          0);
    add(0, 0, 0, 1, 1, RPC + 32'h4,  RPC);
    add(0, 0, 0, 1, 1, RPC + 32'h8,  RPC + 32'h4);
    add(0, 0, 0, 1, 1, RPC + 32'hC,  RPC + 32'h8);
    // Reset again, then stall decode: fill to 4 and hold.
    add(1, 0, 0, 0, 0, RPC,          0);
    add(0, 0, 0, 0, 1, RPC + 32'h4,  RPC);
    add(0, 0, 0, 0, 1, RPC + 32'h8,  RPC);
    add(0, 0, 0, 0, 1, RPC + 32'hC,  RPC);
    add(0, 0, 0, 0, 1, RPC + 32'h10, RPC);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, RPC + 32'h10, RPC);
    // Release: full FIFO pops without pushing first, then streams.
    add(0, 0, 0, 1, 1, RPC + 32'h10, RPC + 32'h4);
    add(0, 0, 0, 1, 1, RPC + 32'h14, RPC + 32'h8);
    add(0, 0, 0, 1, 1, RPC + 32'h18, RPC + 32'hC);
    add(0, 0, 0, 1, 1, RPC + 32'h1C, RPC + 32'h10);
    // Redirect with 3 entries held; old entries must vanish.
    add(0, 1, 32'hBFC00100, 1, 0, 32'hBFC00100, 0);
    add(0, 0, 0, 1, 1, 32'hBFC00104, 32'hBFC00100);
    add(0, 0, 0, 1, 1, 32'hBFC00108, 32'hBFC00104);
    // PC wrap at the top of the address space.
    add(0, 1, 32'hFFFFFFF8, 1, 0, 32'hFFFFFFF8, 0);
    add(0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFF8);
    add(0, 0, 0, 1, 1, 32'h00000000, 32'hFFFFFFFC);
    add(0, 0, 0, 1, 1, 32'h00000004, 32'h00000000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      step();
      check_out(vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_ipc, 1'b0);
    end

    // Misaligned redirect.
    drive(0, 1, 32'hBFC00102, 1);
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    check_out(0, 32'hBFC00102, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out(0, 32'hBFC00102, 0, 1);
    end
`else
    check_out(0, 32'hBFC00100, 0, 0);
    drive(0, 0, 0, 1);
    step();
    check_out(1, 32'hBFC00104, 32'hBFC00100, 0);
    step();
    check_out(1, 32'hBFC00108, 32'hBFC00104, 0);
`endif
    // Aligned redirect recovers (from HALT when the check is built in).
    drive(0, 1, 32'hBFC00200, 1);
    step();
    check_out(0, 32'hBFC00200, 0, 0);
    drive(0, 0, 0, 1);
    step();
    check_out(1, 32'hBFC00204, 32'hBFC00200, 0);

    // Fill a little, then reset on top of a redirect.
    drive(0, 0, 0, 0);
    step();
    check_out(1, 32'hBFC00208, 32'hBFC00200, 0);
    step();
    check_out(1, 32'hBFC0020C, 32'hBFC00200, 0);
    drive(1, 1, 32'hBFC00301, 1);
    step();
    check_out(0, RPC, 0, 0);
    drive(0, 0, 0, 0);
    step();
    check_out(1, RPC + 32'h4, RPC, 0);
    step();
    check_out(1, RPC + 32'h8, RPC, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the CPU: owns the fetch PC, drives the address side of the asynchronous instruction memory, and captures each returned instruction word together with its PC into a small prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. Execute redirects the unit on taken branches and jumps, which flushes all prefetched words.

## Interface
- DATA_WIDTH, 32, instruction word width
- INSTR_WIDTH, 32, address/PC width
- RESET_PC, 32'hBFC00000, fetch PC loaded on reset
- FIFO_DEPTH, 4, prefetch entries; power of two, 2..16

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- PC  out  INSTR_WIDTH  fetch address to instruction memory; equals the fpc register
- imem_instr  in  DATA_WIDTH  instruction word returned combinationally for PC in the same cycle
- redirect_valid  in  1  load a new fetch PC and flush the FIFO
- redirect_pc  in  INSTR_WIDTH  target PC when redirect_valid is high
- instr_valid  out  1  FIFO head holds a valid entry
- instr_ready  in  1  decode accepts the head this cycle
- instr  out  DATA_WIDTH  head instruction word
- instr_pc  out  INSTR_WIDTH  PC of the head instruction
- misalign  out  1  misaligned redirect detected; tied 0 unless FETCH_MISALIGN_CHECK_EN is defined

## Operation
- State: fpc register; FIFO storage of {pc, word}; rd_ptr and wr_ptr of log2(FIFO_DEPTH) bits; count of log2(FIFO_DEPTH)+1 bits; mode ∈ {RUN, HALT}.
- push = (mode==RUN) && (count < FIFO_DEPTH) && !redirect_valid. On push, write {fpc, imem_instr} at wr_ptr, then wr_ptr++ and fpc <= fpc + 4.
- fpc arithmetic is modulo 2^INSTR_WIDTH, so 32'hFFFFFFFC wraps to 0. Pointers wrap modulo FIFO_DEPTH.
- pop = instr_valid && instr_ready && !redirect_valid. On pop, rd_ptr++.
- count updates by +push −pop. Simultaneous push and pop leave count unchanged.
- When full (count==FIFO_DEPTH) there is no push, even if pop is high; fpc holds.
- Redirect has priority over push and pop. It clears count, rd_ptr and wr_ptr to 0 and loads fpc <= redirect_pc. The word fetched in that cycle and any pop are discarded.
- instr_valid = (count != 0). instr and instr_pc come from the entry at rd_ptr. When count==0 these are don't-care.
- Entries leave the FIFO in fetch order, and instr_pc increments by 4 between consecutive entries with no redirect in between.
- Reset: fpc = RESET_PC, count = 0, pointers = 0, mode = RUN, misalign = 0, instr_valid = 0.

## Timing
- PC is registered, and imem_instr is sampled in the same cycle.
- Fetch-to-valid latency: 1 cycle. A word pushed at edge N is visible on instr/instr_valid after edge N.
- First cycle after rst deasserts: PC = RESET_PC, instr_valid = 0. After the next edge, instr_valid = 1 and instr_pc = RESET_PC.
- Redirect at edge N: instr_valid = 0 and PC = redirect_pc after edge N. The first target instruction is valid after edge N+1.
- There is no combinational path from instr_ready or redirect_valid to PC.
- rst asserted mid-operation overrides redirect, push and pop in that cycle.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 still flushes and loads fpc, but sets mode = HALT and misalign = 1.
  - In HALT there is no push and instr_valid stays 0.
  - Only rst, or a redirect with an aligned target, returns the unit to RUN with misalign = 0.
- FETCH_MISALIGN_CHECK_EN undefined:
  - misalign is constant 0 and there is no HALT state.
  - fpc loads redirect_pc[31:2],2'b00, so the target is silently aligned.

## Test plan
- Reset, then hold instr_ready = 1 against a ROM of sequential words → instr_pc = BFC00000, BFC00004, BFC00008… on consecutive cycles, with instr_valid continuous from the second post-reset cycle.
- Hold instr_ready = 0 for 10 cycles → count saturates at 4, PC holds at BFC00010, and no entries are overwritten. Then release → the four entries drain in order (BFC00000..BFC0000C) before BFC00010.
- With the FIFO holding 3 entries, assert redirect_valid with redirect_pc = BFC00100 and instr_ready = 1 → the next cycle has instr_valid = 0 and PC = BFC00100, the following cycle has instr_pc = BFC00100, and none of the old entries appear.
- Redirect to FFFFFFF8, then run → instr_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- Macro defined: redirect to BFC00102 → misalign = 1 and instr_valid stays 0 for 5 cycles. Then redirect to BFC00200 → misalign = 0 and instr_pc = BFC00200 two cycles later. Macro undefined: the same misaligned redirect yields instr_pc = BFC00100.
- Assert rst during a redirect cycle → PC = BFC00000, count = 0, misalign = 0.
